// File: rtl/sync_ff.sv
// Multi-flop synchronizer for one asynchronous bit; latency STAGES clk_in cycles, no backpressure.
// Reset loads RESET_VALUE into every stage so the output starts at the line's idle level.
module sync_ff #(
  parameter int   STAGES      = 2,
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk_in,
  input  logic reset_in,
  input  logic d_in,
  output logic q_out
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d_in};
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      sync_q <= {STAGES{RESET_VALUE}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_out = sync_q[STAGES-1];

endmodule

// File: rtl/serial_deserializer.sv
// Oversampled SPI-style target: words valid SYNC_STAGES+2 cycles after the last raw sclk rise.
// No backpressure on the serial side; a word arriving while one is still held is dropped and flags overrun.
module serial_deserializer #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic             sclk_in,
  input  logic             cs_n_in,
  input  logic             serial_in,
  output logic             serial_out,
  input  logic [WIDTH-1:0] tx_data,
  output logic             tx_taken,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ack,
  output logic             overrun
);

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

  state_t state_q, state_d;

  logic sclk_sync, cs_n_sync, din_sync;
  logic sclk_prev_q, sclk_prev_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] rx_q, rx_d;
  logic [WIDTH-1:0] tx_q, tx_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic done_q, done_d;
  logic valid_q, valid_d;
  logic ovr_q, ovr_d;

  logic frame_start, cnt_clr, rx_shift, word_end, tx_shift, tx_load;

  sync_ff #(.STAGES(SYNC_STAGES), .RESET_VALUE(1'b0)) u_sync_sclk (
    .clk_in(clk_in), .reset_in(reset_in), .d_in(sclk_in), .q_out(sclk_sync)
  );
  sync_ff #(.STAGES(SYNC_STAGES), .RESET_VALUE(1'b1)) u_sync_cs (
    .clk_in(clk_in), .reset_in(reset_in), .d_in(cs_n_in), .q_out(cs_n_sync)
  );
  sync_ff #(.STAGES(SYNC_STAGES), .RESET_VALUE(1'b0)) u_sync_din (
    .clk_in(clk_in), .reset_in(reset_in), .d_in(serial_in), .q_out(din_sync)
  );

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (!cs_n_sync) state_d = ST_ACTIVE;
      ST_ACTIVE: if (cs_n_sync)  state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // The falling edge right after a wrap is skipped (counter is 0) so the reloaded MSB stays on the line.
  always_comb begin
    frame_start = 1'b0;
    cnt_clr     = 1'b0;
    rx_shift    = 1'b0;
    word_end    = 1'b0;
    tx_shift    = 1'b0;
    serial_out  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        frame_start = !cs_n_sync;
        cnt_clr     = 1'b1;
      end
      ST_ACTIVE: begin
        serial_out = tx_q[WIDTH-1];
        if (cs_n_sync) begin
          cnt_clr = 1'b1;
        end else begin
          rx_shift = sclk_sync & ~sclk_prev_q;
          word_end = rx_shift & (bit_cnt_q == LAST_BIT);
          tx_shift = ~sclk_sync & sclk_prev_q & (bit_cnt_q != '0);
        end
      end
      default: cnt_clr = 1'b1;
    endcase
    tx_load  = frame_start | word_end;
    tx_taken = tx_load & ~reset_in;
  end

  always_comb begin
    sclk_prev_d = sclk_sync;
    bit_cnt_d   = bit_cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    done_d      = word_end;
    hold_d      = hold_q;
    valid_d     = valid_q;
    ovr_d       = ovr_q;

    if (cnt_clr || word_end) begin
      bit_cnt_d = '0;
    end else if (rx_shift) begin
      bit_cnt_d = bit_cnt_q + CNT_W'(1);
    end

    if (frame_start) begin
      rx_d = '0;
    end else if (rx_shift) begin
      rx_d = {rx_q[WIDTH-2:0], din_sync};
    end

    if (tx_load) begin
      tx_d = tx_data;
    end else if (tx_shift) begin
      tx_d = {tx_q[WIDTH-2:0], 1'b0};
    end

    if (valid_q && data_ack) begin
      valid_d = 1'b0;
      hold_d  = '0;
    end
    // Completed word sits in rx_q for the cycle after the final shift, hence the +2 latency.
    if (done_q) begin
      if (!valid_q || data_ack) begin
        hold_d  = rx_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      sclk_prev_q <= 1'b0;
      bit_cnt_q   <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      done_q      <= 1'b0;
      hold_q      <= '0;
      valid_q     <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      sclk_prev_q <= sclk_prev_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      done_q      <= done_d;
      hold_q      <= hold_d;
      valid_q     <= valid_d;
      ovr_q       <= ovr_d;
    end
  end

  assign data_out   = valid_q ? hold_q : '0;
  assign data_valid = valid_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_serial_deserializer.sv
// Scoreboard bench: expected words queued as frames are driven, compared when the consumer acks.
module tb_serial_deserializer;

  localparam int WIDTH = 8;
  localparam int SYNC  = 2;

  logic             clk_in    = 1'b0;
  logic             reset_in  = 1'b1;
  logic             sclk_in   = 1'b0;
  logic             cs_n_in   = 1'b1;
  logic             serial_in = 1'b0;
  logic [WIDTH-1:0] tx_data   = '0;
  logic             data_ack  = 1'b0;
  logic             serial_out;
  logic             tx_taken;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             overrun;

  int tests     = 0;
  int fails     = 0;
  int taken_cnt = 0;
  int base;
  logic [WIDTH-1:0] sb_q[$];

  serial_deserializer #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC)) dut (
    .clk_in    (clk_in),
    .reset_in  (reset_in),
    .sclk_in   (sclk_in),
    .cs_n_in   (cs_n_in),
    .serial_in (serial_in),
    .serial_out(serial_out),
    .tx_data   (tx_data),
    .tx_taken  (tx_taken),
    .data_out  (data_out),
    .data_valid(data_valid),
    .data_ack  (data_ack),
    .overrun   (overrun)
  );

  always #5 clk_in = ~clk_in;

  always @(negedge clk_in) begin
    if (tx_taken === 1'b1) taken_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic sb_compare(input string tag);
    logic [WIDTH-1:0] exp;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_nonempty"}, sb_q.size(), 1);
    end else begin
      exp = sb_q.pop_front();
      chk(tag, data_out, exp);
    end
  endtask

  task automatic consume(input string tag);
    chk({tag, "_vld"}, data_valid, 1);
    sb_compare(tag);
    data_ack = 1'b1;
    tick(1);
    data_ack = 1'b0;
    chk({tag, "_vld_clr"}, data_valid, 0);
    chk({tag, "_dout_zero"}, data_out, 0);
  endtask

  // mode 0: plain, 1: check delivery latency on last bit, 2: ack coincident with delivery
  task automatic send(input logic [WIDTH-1:0] w, input int nbits, input int mode,
                      input bit txchk, input logic [WIDTH-1:0] txexp);
    for (int i = 0; i < nbits; i++) begin
      serial_in = w[WIDTH-1-i];
      sclk_in   = 1'b0;
      tick(4);
      if (txchk) chk($sformatf("tx_bit%0d", i), serial_out, txexp[WIDTH-1-i]);
      sclk_in = 1'b1;
      if (i == nbits - 1 && mode == 1) begin
        tick(SYNC + 1);
        chk("lat_pre", data_valid, 0);
        tick(1);
        chk("lat_hit", data_valid, 1);
      end else if (i == nbits - 1 && mode == 2) begin
        tick(SYNC + 1);
        chk("co_vld_pre", data_valid, 1);
        sb_compare("co_held");
        data_ack = 1'b1;
        tick(1);
        data_ack = 1'b0;
        chk("co_vld_post", data_valid, 1);
      end else begin
        tick(4);
      end
    end
    sclk_in = 1'b0;
  endtask

  task automatic do_reset();
    reset_in  = 1'b1;
    cs_n_in   = 1'b1;
    sclk_in   = 1'b0;
    serial_in = 1'b0;
    data_ack  = 1'b0;
    tick(2);
    reset_in = 1'b0;
    tick(2);
  endtask

  initial begin
    tick(3);
    chk("rst_vld", data_valid, 0);
    chk("rst_dout", data_out, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_sout", serial_out, 0);
    chk("rst_taken", tx_taken, 0);
    reset_in = 1'b0;
    tick(2);

    // single word with latency and response bits
    tx_data = 8'h3C;
    base    = taken_cnt;
    cs_n_in = 1'b0;
    tick(6);
    chk("a_taken_start", taken_cnt, base + 1);
    sb_q.push_back(8'hA5);
    send(8'hA5, 8, 1, 1'b1, 8'h3C);
    tick(4);
    chk("a_taken_wrap", taken_cnt, base + 2);
    consume("a_word");
    cs_n_in = 1'b1;
    tick(6);

    // back-to-back without ack -> overrun, then recovery
    base    = taken_cnt;
    cs_n_in = 1'b0;
    tick(6);
    sb_q.push_back(8'h12);
    send(8'h12, 8, 0, 1'b0, 8'h00);
    send(8'h34, 8, 0, 1'b0, 8'h00);
    tick(6);
    chk("b_ovr", overrun, 1);
    chk("b_held", data_out, 8'h12);
    consume("b_first");
    sb_q.push_back(8'h56);
    send(8'h56, 8, 0, 1'b0, 8'h00);
    tick(6);
    consume("b_third");
    chk("b_ovr_sticky", overrun, 1);
    chk("b_taken", taken_cnt, base + 4);
    cs_n_in = 1'b1;
    tick(6);

    // ack coincident with completion
    do_reset();
    chk("c_ovr_rst", overrun, 0);
    cs_n_in = 1'b0;
    tick(6);
    sb_q.push_back(8'h12);
    sb_q.push_back(8'h34);
    send(8'h12, 8, 0, 1'b0, 8'h00);
    send(8'h34, 8, 2, 1'b0, 8'h00);
    chk("c_ovr", overrun, 0);
    tick(4);
    consume("c_second");
    cs_n_in = 1'b1;
    tick(6);

    // aborted partial word
    cs_n_in = 1'b0;
    tick(6);
    send(8'hA0, 5, 0, 1'b0, 8'h00);
    cs_n_in = 1'b1;
    tick(6);
    chk("d_no_deliver", data_valid, 0);
    cs_n_in = 1'b0;
    tick(6);
    sb_q.push_back(8'hFF);
    send(8'hFF, 8, 0, 1'b0, 8'h00);
    tick(6);
    chk("d_ovr", overrun, 0);
    consume("d_word");
    cs_n_in = 1'b1;
    tick(6);

    // reset mid-frame
    tx_data = 8'hFF;
    cs_n_in = 1'b0;
    tick(6);
    send(8'h5A, 8, 0, 1'b0, 8'h00);
    send(8'h5B, 8, 0, 1'b0, 8'h00);
    send(8'hF0, 4, 0, 1'b0, 8'h00);
    tick(3);
    chk("e_pre_ovr", overrun, 1);
    chk("e_pre_sout", serial_out, 1);
    reset_in = 1'b1;
    tick(1);
    chk("e_rst_vld", data_valid, 0);
    chk("e_rst_dout", data_out, 0);
    chk("e_rst_ovr", overrun, 0);
    chk("e_rst_sout", serial_out, 0);
    chk("e_rst_taken", tx_taken, 0);
    reset_in = 1'b0;
    cs_n_in  = 1'b1;
    tick(6);
    cs_n_in = 1'b0;
    tick(6);
    sb_q.push_back(8'h81);
    send(8'h81, 8, 0, 1'b0, 8'h00);
    tick(6);
    chk("e_ovr", overrun, 0);
    consume("e_word");
    cs_n_in = 1'b1;
    tick(6);

    chk("sb_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
